// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian request path: state codes and default timing.
// Used by the key conditioner, the traffic-light controller and the bench.
// No logic here; only constants and a compile-time helper.
package ped_pkg;

  // Conditioner state encoding (3-bit codes, also decoded by the controller)
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEBOUNCE = 3'd1;
  localparam logic [2:0] ARMED    = 3'd2;
  localparam logic [2:0] SERVED   = 3'd3;
  localparam logic [2:0] LOCKOUT  = 3'd4;

  // Default timing, in clock cycles
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int LOCKOUT_CYCLES_DEF  = 10;

  // Larger of two integers, for sizing the shared counter at elaboration
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the clock domain.
// Latency: 2 cycles from d to q. No backpressure; the level is sampled every cycle.
// Ports: clock, reset (sync, active-high, clears both flops), d (async in), q (sync out).
module bit_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ped_key_conditioner.sv
// Turns a bouncing pedestrian push-button into one clean request level (key) per press.
// Latency: key rises DEBOUNCE_CYCLES+2 edges after the first edge sampling a steady press.
// Backpressure: key holds until green acknowledges; a lockout then ignores presses until release.
// Ports: clock, reset (sync, active-high), button_raw (async button), green (walk ack),
//        key (request level to controller), busy (high whenever not idle).
module ped_key_conditioner
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  input  logic green,
  output logic key,
  output logic busy
);

  // One counter serves both debounce and lockout timing; it only needs to
  // reach the larger terminal value minus one.
  localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, LOCKOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             btn_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  bit_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (button_raw),
    .q     (btn_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn_s) begin
          state_nxt = DEBOUNCE;
          cnt_nxt   = CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ARMED: begin
        // Button activity is irrelevant here; only the acknowledge matters.
        if (green) begin
          state_nxt = SERVED;
        end
      end
      SERVED: begin
        // Wait for the walk phase to end before timing the lockout.
        if (!green) begin
          state_nxt = LOCKOUT;
          cnt_nxt   = '0;
        end
      end
      LOCKOUT: begin
        // Counter saturates at the terminal count; a still-held button keeps
        // us here so that one long press can never raise a second request.
        if (cnt == LOCK_LAST) begin
          if (!btn_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the registered state only, so no input reaches them combinationally.
  assign key  = (state == ARMED);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ped_key_conditioner.sv
module tb_ped_key_conditioner;

  localparam int DEB  = ped_pkg::DEBOUNCE_CYCLES_DEF;
  localparam int LOCK = ped_pkg::LOCKOUT_CYCLES_DEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic button_raw = 1'b0;
  logic green = 1'b0;
  logic key;
  logic busy;

  int checks   = 0;
  int failures = 0;

  ped_key_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .button_raw (button_raw),
    .green      (green),
    .key        (key),
    .busy       (busy)
  );

  initial forever #5 clock = ~clock;

  // Behavioural model: a press is accepted once the synchronised button has been
  // seen high for DEB consecutive samples while waiting; after the walk ends the
  // path is blocked until LOCK edges have elapsed and the button is seen released.
  typedef enum int {M_WAIT, M_ARMED, M_SERVED, M_LOCK} mphase_t;
  mphase_t m_phase   = M_WAIT;
  int      m_run     = 0;
  int      m_edge    = 0;
  int      m_lock_at = 0;
  logic [1:0] m_sync = 2'b00;
  logic    m_key  = 1'b0;
  logic    m_busy = 1'b0;

  task automatic model_step();
    logic s;
    s = m_sync[1];
    if (reset) begin
      m_sync  = 2'b00;
      m_phase = M_WAIT;
      m_run   = 0;
    end else begin
      m_edge++;
      case (m_phase)
        M_WAIT: begin
          m_run = s ? m_run + 1 : 0;
          if (m_run == DEB) begin
            m_phase = M_ARMED;
            m_run   = 0;
          end
        end
        M_ARMED:  if (green) m_phase = M_SERVED;
        M_SERVED: if (!green) begin
          m_phase   = M_LOCK;
          m_lock_at = m_edge;
        end
        M_LOCK: if ((m_edge - m_lock_at) >= LOCK && !s) begin
          m_phase = M_WAIT;
          m_run   = 0;
        end
        default: m_phase = M_WAIT;
      endcase
      m_sync = {m_sync[0], button_raw};
    end
    m_key  = (m_phase == M_ARMED);
    m_busy = (m_phase != M_WAIT) || (m_run > 0);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus key pulse counting.
  logic cmp_en  = 1'b0;
  logic key_d   = 1'b0;
  int   pulses  = 0;
  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      chk("cyc_key", key, m_key);
      chk("cyc_busy", busy, m_busy);
      if (key && !key_d) pulses++;
    end
    key_d = key;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic expect_kb(input string name, input logic k, input logic b);
    chk({name, "_key"}, key, k);
    chk({name, "_busy"}, busy, b);
    chk({name, "_mkey"}, m_key, k);
    chk({name, "_mbusy"}, m_busy, b);
  endtask

  task automatic serve_and_release();
    green = 1'b1;
    step(1);
    green = 1'b0;
    button_raw = 1'b0;
    step(1);
    step(LOCK);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step(3);
    expect_kb("reset", 1'b0, 1'b0);
    reset = 1'b0;
    cmp_en = 1'b1;
    step(2);

    // Clean press, served, released with green dropping
    button_raw = 1'b1;
    step(5);
    expect_kb("clean_e5", 1'b0, 1'b1);
    step(1);
    expect_kb("clean_e6", 1'b1, 1'b1);
    step(3);
    green = 1'b1;
    step(1);
    expect_kb("clean_e10", 1'b0, 1'b1);
    step(4);
    green = 1'b0;
    button_raw = 1'b0;
    step(1);
    step(9);
    expect_kb("clean_e24", 1'b0, 1'b1);
    step(1);
    expect_kb("clean_e25", 1'b0, 1'b0);

    // Bounce: 1,1,1,0 never reaches a full debounce run
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      button_raw = (i % 4 != 3);
      step(1);
    end
    button_raw = 1'b0;
    step(4);
    expect_kb("bounce_end", 1'b0, 1'b0);
    chk("bounce_pulses", (pulses == 0), 1'b1);

    // Held button through serve and 30 more cycles
    pulses = 0;
    button_raw = 1'b1;
    step(6);
    expect_kb("held_armed", 1'b1, 1'b1);
    green = 1'b1;
    step(1);
    green = 1'b0;
    step(1);
    step(30);
    expect_kb("held_lock", 1'b0, 1'b1);
    button_raw = 1'b0;
    step(2);
    expect_kb("held_rel2", 1'b0, 1'b1);
    step(1);
    expect_kb("held_rel3", 1'b0, 1'b0);
    chk("held_pulses", (pulses == 1), 1'b1);

    // Early green: key lasts exactly one cycle
    pulses = 0;
    green = 1'b1;
    button_raw = 1'b1;
    step(6);
    expect_kb("early_e6", 1'b1, 1'b1);
    step(1);
    expect_kb("early_e7", 1'b0, 1'b1);
    green = 1'b0;
    button_raw = 1'b0;
    step(1);
    step(LOCK - 1);
    expect_kb("early_lock", 1'b0, 1'b1);
    step(1);
    expect_kb("early_idle", 1'b0, 1'b0);
    chk("early_pulses", (pulses == 1), 1'b1);

    // Reset while armed with the button held
    button_raw = 1'b1;
    step(6);
    expect_kb("rst_armed", 1'b1, 1'b1);
    reset = 1'b1;
    step(1);
    expect_kb("rst_edge", 1'b0, 1'b0);
    reset = 1'b0;
    step(5);
    expect_kb("rst_e5", 1'b0, 1'b1);
    step(1);
    expect_kb("rst_e6", 1'b1, 1'b1);
    serve_and_release();
    expect_kb("rst_done", 1'b0, 1'b0);

    // Press during lockout, released before terminal count
    pulses = 0;
    button_raw = 1'b1;
    step(6);
    green = 1'b1;
    step(1);
    green = 1'b0;
    button_raw = 1'b0;
    step(1);
    step(3);
    button_raw = 1'b1;
    step(4);
    button_raw = 1'b0;
    step(4);
    expect_kb("lockpress_idle", 1'b0, 1'b0);
    chk("lockpress_pulses", (pulses == 1), 1'b1);

    // Fresh press with green toggling during debounce
    button_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      green = (i % 2 == 0);
      step(1);
    end
    green = 1'b0;
    step(1);
    expect_kb("fresh_e5", 1'b0, 1'b1);
    step(1);
    expect_kb("fresh_e6", 1'b1, 1'b1);
    serve_and_release();
    expect_kb("fresh_done", 1'b0, 1'b0);

    cmp_en = 1'b0;
    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
